// File: rtl/sync_mem_dp.sv
// Simple-dual-port RAM with byte-enable writes, a clear engine and READ_LAT (1 or 2) read latency.
// No backpressure: while busy, reads, writes and clr requests are dropped.
module sync_mem_dp #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter int               READ_LAT = 1,
  parameter int               RDW_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  output logic               busy,
  input  logic               we,
  input  logic [DEPTH-1:0]   wrAddr,
  input  logic [WIDTH-1:0]   wrData,
  input  logic [WIDTH/8-1:0] wrBe,
  input  logic               re,
  input  logic [DEPTH-1:0]   rdAddr,
  output logic [WIDTH-1:0]   rdData,
  output logic               rdValid
);

  localparam int NDEPTH = 1 << DEPTH;
  localparam int NBYTES = WIDTH / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, stateNext;
  logic [DEPTH-1:0] clrAddr;
  logic [WIDTH-1:0] mem [NDEPTH];
  logic             wrAccept, rdAccept;
  logic [WIDTH-1:0] oldWord, mergedWord, readWord;
  logic [WIDTH-1:0] s1Data;
  logic             s1Valid;

  always_comb begin
    stateNext = state;
    wrAccept  = 1'b0;
    rdAccept  = 1'b0;
    case (state)
      CLEAR: begin
        if (clrAddr == '1) stateNext = READY;
      end
      READY: begin
        if (clr) begin
          stateNext = CLEAR;
        end else begin
          wrAccept = we;
          rdAccept = re;
        end
      end
      default: stateNext = CLEAR;
    endcase
  end

  assign busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clrAddr <= '0;
    end else begin
      state <= stateNext;
      if (state == CLEAR) begin
        clrAddr <= clrAddr + 1'b1;
      end else if (clr) begin
        clrAddr <= '0;
      end
    end
  end

  // Storage is deliberately not reset; the sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clrAddr] <= INIT_VAL;
    end else if (wrAccept) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wrBe[b]) mem[wrAddr][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  always_comb begin
    oldWord    = mem[rdAddr];
    mergedWord = oldWord;
    for (int b = 0; b < NBYTES; b++) begin
      if (wrBe[b]) mergedWord[8*b +: 8] = wrData[8*b +: 8];
    end
    readWord = oldWord;
    if (RDW_MODE == 1 && wrAccept && wrAddr == rdAddr) readWord = mergedWord;
  end

  // Data registers only load on a valid beat so rdData holds between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1Valid <= 1'b0;
      s1Data  <= '0;
    end else begin
      s1Valid <= rdAccept;
      if (rdAccept) s1Data <= readWord;
    end
  end

  generate
    if (READ_LAT == 2) begin : gLat2
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdValid <= 1'b0;
          rdData  <= '0;
        end else begin
          rdValid <= s1Valid;
          if (s1Valid) rdData <= s1Data;
        end
      end
    end else begin : gLat1
      assign rdValid = s1Valid;
      assign rdData  = s1Data;
    end
  endgenerate

endmodule

// File: tb/tb_sync_mem_dp.sv
// Bench for sync_mem_dp: one read-first/latency-1 instance and one write-first/latency-2 instance.
module tb_sync_mem_dp;

  logic        clk, rst, clr, we, re;
  logic [3:0]  wrAddr, rdAddr;
  logic [15:0] wrData;
  logic [1:0]  wrBe;
  logic        d0Busy, d0RdValid, d1Busy, d1RdValid;
  logic [15:0] d0RdData, d1RdData;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[14];

  sync_mem_dp #(.WIDTH(16), .DEPTH(4), .READ_LAT(1), .RDW_MODE(0), .INIT_VAL(16'hA5A5)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .busy(d0Busy), .we(we), .wrAddr(wrAddr), .wrData(wrData),
    .wrBe(wrBe), .re(re), .rdAddr(rdAddr), .rdData(d0RdData), .rdValid(d0RdValid));

  sync_mem_dp #(.WIDTH(16), .DEPTH(4), .READ_LAT(2), .RDW_MODE(1), .INIT_VAL(16'hA5A5)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .busy(d1Busy), .we(we), .wrAddr(wrAddr), .wrData(wrData),
    .wrBe(wrBe), .re(re), .rdAddr(rdAddr), .rdData(d1RdData), .rdValid(d1RdValid));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Scoreboards: each result must arrive on its due cycle, in order.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst) begin
      if (q0.size() > 0 && q0[0].due < cyc) begin
        e = q0.pop_front();
        compared++; mismatched++;
        $display("FAIL rd0_missing: no rdValid by cycle %0d, required %h due at %0d", cyc, e.data, e.due);
      end
      if (d0RdValid) begin
        compared++;
        if (q0.size() == 0) begin
          mismatched++;
          $display("FAIL rd0_unexpected: rdValid with %h at cycle %0d, required no result", d0RdData, cyc);
        end else begin
          e = q0.pop_front();
          if (d0RdData !== e.data || cyc != e.due) begin
            mismatched++;
            $display("FAIL rd0_data: got %h at cycle %0d, required %h at cycle %0d", d0RdData, cyc, e.data, e.due);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      if (q1.size() > 0 && q1[0].due < cyc) begin
        e = q1.pop_front();
        compared++; mismatched++;
        $display("FAIL rd1_missing: no rdValid by cycle %0d, required %h due at %0d", cyc, e.data, e.due);
      end
      if (d1RdValid) begin
        compared++;
        if (q1.size() == 0) begin
          mismatched++;
          $display("FAIL rd1_unexpected: rdValid with %h at cycle %0d, required no result", d1RdData, cyc);
        end else begin
          e = q1.pop_front();
          if (d1RdData !== e.data || cyc != e.due) begin
            mismatched++;
            $display("FAIL rd1_data: got %h at cycle %0d, required %h at cycle %0d", d1RdData, cyc, e.data, e.due);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_busy0"}, 32'(d0Busy), 32'd1);
    check({tag, "_busy1"}, 32'(d1Busy), 32'd1);
    check({tag, "_rdValid0"}, 32'(d0RdValid), 32'd0);
    check({tag, "_rdValid1"}, 32'(d1RdValid), 32'd0);
    check({tag, "_rdData0"}, 32'(d0RdData), 32'd0);
    check({tag, "_rdData1"}, 32'(d1RdData), 32'd0);
  endtask

  task automatic pushRd(input logic [15:0] e0, input logic [15:0] e1);
    q0.push_back('{e0, cyc + 1});
    q1.push_back('{e1, cyc + 2});
  endtask

  task automatic setIdle();
    clr = 0; we = 0; re = 0; wrAddr = '0; wrData = '0; wrBe = '0; rdAddr = '0;
  endtask

  task automatic drive(input logic iwe, input logic [3:0] wa, input logic [15:0] wd, input logic [1:0] be,
                       input logic ire, input logic [3:0] ra, input logic iclr);
    we = iwe; wrAddr = wa; wrData = wd; wrBe = be; re = ire; rdAddr = ra; clr = iclr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    setIdle();
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Counts busy cycles of both instances, bounded so a stuck sweep still reaches the summary.
  task automatic waitSweep(input string name);
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!d0Busy && !d1Busy) break;
      n0 += int'(d0Busy);
      n1 += int'(d1Busy);
    end
    check({name, "_busyCycles0"}, 32'(n0), 32'd16);
    check({name, "_busyCycles1"}, 32'(n1), 32'd16);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'd3,  16'h1234, 2'b11, 1'b0, 4'd0,  16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 4'd3,  16'hFF00, 2'b10, 1'b0, 4'd0,  16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd3,  16'hFF34, 16'hFF34};
    tbl[3]  = '{1'b1, 4'd5,  16'h0001, 2'b11, 1'b0, 4'd0,  16'h0000, 16'h0000};
    tbl[4]  = '{1'b1, 4'd5,  16'h0002, 2'b11, 1'b1, 4'd5,  16'h0001, 16'h0002};
    tbl[5]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd5,  16'h0002, 16'h0002};
    tbl[6]  = '{1'b1, 4'd6,  16'hBBCC, 2'b01, 1'b1, 4'd6,  16'hA5A5, 16'hA5CC};
    tbl[7]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd6,  16'hA5CC, 16'hA5CC};
    tbl[8]  = '{1'b1, 4'd9,  16'hFFFF, 2'b00, 1'b1, 4'd9,  16'hA5A5, 16'hA5A5};
    tbl[9]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd9,  16'hA5A5, 16'hA5A5};
    tbl[10] = '{1'b1, 4'd10, 16'h1111, 2'b11, 1'b1, 4'd11, 16'hA5A5, 16'hA5A5};
    tbl[11] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd10, 16'h1111, 16'h1111};
    tbl[12] = '{1'b1, 4'd0,  16'hCAFE, 2'b11, 1'b1, 4'd3,  16'hFF34, 16'hFF34};
    tbl[13] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd0,  16'hCAFE, 16'hCAFE};

    setIdle();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 checkResetOutputs("asyncReset");
    repeat (3) @(posedge clk);
    #1 checkResetOutputs("heldReset");

    // Power-up sweep, then back-to-back reads of the cleared array.
    rst = 1'b1;
    waitSweep("powerUp");
    for (int i = 0; i < 16; i++) begin
      pushRd(16'hA5A5, 16'hA5A5);
      drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i), 1'b0);
    end
    idle(4);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].re) pushRd(tbl[i].exp0, tbl[i].exp1);
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra, 1'b0);
    end
    idle(4);

    // Distinct word per address so ordering of streamed reads is visible.
    for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 16'(i * 257), 2'b11, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      pushRd(16'(i * 257), 16'(i * 257));
      drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i), 1'b0);
    end
    idle(4);

    // A read in flight survives clr; the colliding write and read are dropped.
    pushRd(16'h0101, 16'h0101);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd1, 1'b0);
    drive(1'b1, 4'd7, 16'hBEEF, 2'b11, 1'b1, 4'd7, 1'b1);
    setIdle();
    waitSweep("clrCollision");
    pushRd(16'hA5A5, 16'hA5A5);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd7, 1'b0);
    pushRd(16'hA5A5, 16'hA5A5);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3, 1'b0);
    idle(4);
    check("preReset_rdData0", 32'(d0RdData), 32'h0000A5A5);

    // Reset in the middle of a sweep.
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b1);
    setIdle();
    repeat (7) @(posedge clk);
    #1 check("midSweep_busy", 32'(d0Busy), 32'd1);
    rst = 1'b0;
    #1 checkResetOutputs("midSweepReset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    waitSweep("afterMidReset");
    pushRd(16'hA5A5, 16'hA5A5);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0, 1'b0);
    pushRd(16'hA5A5, 16'hA5A5);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd15, 1'b0);
    idle(4);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_mem_dp.md
# sync_mem_dp

Parametrised simple-dual-port synchronous RAM: one write port with byte enables and one independent read port. It is the next generation of the team's single-port async/sync memories. It adds a configurable read latency, a selectable read-during-write policy, and a hardware clear engine that sweeps every location to a known value after reset or on request. It sits between datapath producers and consumers wherever a small buffered store with defined power-up contents is needed.

## Interface
Parameters:
- WIDTH, default 8: data word width in bits; must be a multiple of 8.
- DEPTH, default 4: address width in bits; NDEPTH = 1<<DEPTH words.
- READ_LAT, default 1: read latency in cycles; legal values are 1 or 2.
- RDW_MODE, default 0: same-address read-during-write policy; 0 = read-first (old data), 1 = write-first (new data).
- INIT_VAL, default 0: WIDTH-bit value written to every word by the clear engine.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- clr, input, 1: one-cycle request to re-run the clear sweep.
- busy, output, 1: high while a clear sweep is in progress.
- we, input, 1: write enable.
- wrAddr, input, DEPTH: write address.
- wrData, input, WIDTH: write data.
- wrBe, input, WIDTH/8: byte enables; bit k qualifies wrData[8k+7:8k].
- re, input, 1: read enable.
- rdAddr, input, DEPTH: read address.
- rdData, output, WIDTH: read data.
- rdValid, output, 1: rdData holds the result of an accepted read.

## Operation
- The state machine has two states: CLEAR and READY.
  - Reset (rst=0) forces CLEAR and sets clrAddr=0, busy=1, rdData=0, rdValid=0, and empties the latency pipeline.
  - The storage array itself is not reset.
- CLEAR:
  - Each cycle, write INIT_VAL (all bytes) to mem[clrAddr] and increment clrAddr.
  - After writing clrAddr==NDEPTH-1, go to READY with busy=0 on the next cycle. The sweep always takes exactly NDEPTH cycles.
  - we, re and clr are ignored; no read is accepted and rdValid stays 0.
- READY:
  - Writes: we=1 updates only the bytes of mem[wrAddr] whose wrBe bit is 1. we=1 with wrBe=0 is a no-op.
  - Reads: re=1 accepts a read of mem[rdAddr].
  - Simultaneous clr=1 with we/re: clr wins. The write and read are dropped and the next state is CLEAR with clrAddr=0.
  - A read already in the latency pipeline when clr is sampled still completes with its captured data.
- Read-during-write (we=1, re=1, wrAddr==rdAddr, same cycle):
  - RDW_MODE=0: return the pre-write word.
  - RDW_MODE=1: return the merged word (enabled bytes from wrData, others from the old word).
  - Different addresses: no interaction.
- Address arithmetic: clrAddr is DEPTH bits, and its final increment wraps to 0 harmlessly. User addresses cover the full range with no out-of-range case.

## Timing
- Write: the array updates at the rising edge where we=1 is sampled. A read of the same address in a later cycle sees the new data.
- Read latency:
  - READ_LAT=1: rdData/rdValid are registered one edge after the re sample.
  - READ_LAT=2: an extra output register is added, so they appear two edges after.
  - Back-to-back reads give one result per cycle.
- rdValid: high for exactly one cycle per accepted read. When rdValid=0, rdData holds its last value.
- busy:
  - Goes high in the cycle after clr is sampled in READY.
  - Is high asynchronously during reset.
  - Falls NDEPTH cycles after CLEAR is entered.
- Reset mid-sweep or mid-read: state, pipeline and outputs return to reset values immediately, and the sweep restarts from address 0 after rst is released.

## Test plan
All scenarios use WIDTH=16, DEPTH=4, INIT_VAL=16'hA5A5.
- Power-up sweep: release rst and wait.
  - busy must be high for exactly 16 cycles, then low.
  - Reads of addresses 0..15 must each return 16'hA5A5 with the READ_LAT latency.
- Byte enables: write 16'h1234 with wrBe=2'b11 to addr 3, then 16'hFF00 with wrBe=2'b10 → reading addr 3 returns 16'hFF34.
- Read-during-write: addr 5 holds 16'h0001; write 16'h0002 to addr 5 while reading addr 5 in the same cycle.
  - RDW_MODE=0 returns 16'h0001.
  - RDW_MODE=1 returns 16'h0002.
- Latency/throughput: issue reads of addresses 0..15 on consecutive cycles.
  - READ_LAT=1 and 2 must each give 16 consecutive rdValid pulses, in order, offset by exactly 1 and 2 cycles respectively.
- clr collision: in READY, assert clr together with we=1 (addr 7, 16'hBEEF) and re=1.
  - The write and the read are dropped (no rdValid).
  - busy is high for 16 cycles.
  - Addr 7 then reads 16'hA5A5.
- Reset mid-sweep: drop rst at sweep cycle 8 → busy, rdValid and rdData return to reset values at once, and after release the full 16-cycle sweep repeats.
